// File: rtl/mips_pkg.sv
// Shared encodings for the instruction/data memory arbiter.
package mips_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_ISSUE = 2'd1,
      ARB_RESP  = 2'd2
   } arb_state_e;

   localparam logic OWN_I = 1'b0;
   localparam logic OWN_D = 1'b1;

endpackage

// File: rtl/arb_starve_cnt.sv
// Counts consecutive D grants taken while fetch waits; saturates at STARVE_MAX.
module arb_starve_cnt
   import mips_pkg::*;
#(
   parameter int STARVE_MAX = 4,
   parameter int CW         = $clog2(STARVE_MAX + 1)
) (
   input  logic clk,
   input  logic rst,
   input  logic grant_i,
   input  logic grant_d,
   input  logic i_pend,
   output logic starved
);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (grant_d && i_pend) begin
         if (cnt != CW'(STARVE_MAX))
            cnt <= cnt + 1'b1;
      end else if (grant_i || grant_d) begin
         cnt <= '0;
      end
   end

   assign starved = (cnt == CW'(STARVE_MAX));

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch (I) and data (D) accesses onto one single-ported memory.
// D has priority; the starvation counter forces an I grant after STARVE_MAX D wins.
module mem_arbiter
   import mips_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [DATA_W-1:0] i_rdata,
   output logic              i_ready,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_ready,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack
);

   arb_state_e state;
   logic       owner;
   logic       starved;
   logic       grant_d;
   logic       grant_i;

   assign grant_d = (state == ARB_IDLE) && d_req && (!i_req || !starved);
   assign grant_i = (state == ARB_IDLE) && i_req && !grant_d;

   arb_starve_cnt #(.STARVE_MAX(STARVE_MAX)) u_starve (
      .clk     (clk),
      .rst     (rst),
      .grant_i (grant_i),
      .grant_d (grant_d),
      .i_pend  (i_req),
      .starved (starved)
   );

   // mem_req / ready are plain flops, so nothing reaches them combinationally.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ARB_IDLE;
         owner     <= OWN_I;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         i_rdata   <= '0;
         d_rdata   <= '0;
         i_ready   <= 1'b0;
         d_ready   <= 1'b0;
      end else begin
         case (state)
            ARB_IDLE: begin
               if (grant_d) begin
                  owner     <= OWN_D;
                  mem_addr  <= d_addr;
                  mem_wdata <= d_wdata;
                  mem_we    <= d_we;
                  mem_req   <= 1'b1;
                  state     <= ARB_ISSUE;
               end else if (grant_i) begin
                  owner     <= OWN_I;
                  mem_addr  <= i_addr;
                  mem_wdata <= '0;
                  mem_we    <= 1'b0;
                  mem_req   <= 1'b1;
                  state     <= ARB_ISSUE;
               end
            end
            ARB_ISSUE: begin
               if (mem_ack) begin
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
                  if (owner == OWN_I) begin
                     i_rdata <= mem_rdata;
                     i_ready <= 1'b1;
                  end else begin
                     if (!mem_we)
                        d_rdata <= mem_rdata;
                     d_ready <= 1'b1;
                  end
                  state <= ARB_RESP;
               end
            end
            ARB_RESP: begin
               i_ready <= 1'b0;
               d_ready <= 1'b0;
               state   <= ARB_IDLE;
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: access table, grant-order streams, reset and stray acks.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_req, d_req, d_we, mem_ack;
   logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
   logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
   logic        i_ready, d_ready, mem_req, mem_we;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_ready(d_ready),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   typedef struct {
      logic        is_d;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          wt;
      logic        drop;
      logic        stray;
   } vec_t;

   typedef struct {
      logic        is_d;
      logic [31:0] rdata;
      int          lat;
   } exp_t;

   int    n_cmp = 0;
   int    n_err = 0;
   exp_t  sb[$];
   logic  port_q[$];
   logic [31:0] exp_i = 32'h0;
   logic [31:0] exp_d = 32'h0;
   vec_t  vecs[6];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One isolated access; memory acks on issue cycle wt+1.
   task automatic do_access(input vec_t v);
      exp_t e, g;
      int   cyc, issue_n;
      bit   done;
      e.is_d  = v.is_d;
      e.lat   = 2 + v.wt;
      if (!v.is_d) exp_i = v.rdata;
      else if (!v.we) exp_d = v.rdata;
      e.rdata = v.is_d ? exp_d : exp_i;
      sb.push_back(e);
      if (v.is_d) begin
         d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
      end else begin
         i_req = 1'b1; i_addr = v.addr;
      end
      cyc = 0; issue_n = 0; done = 0;
      while (!done && cyc < 40) begin
         mem_ack = 1'b0;
         if (mem_req) begin
            issue_n++;
            chk("mem_addr", 64'(mem_addr), 64'(v.addr));
            chk("mem_we", 64'(mem_we), 64'(v.is_d & v.we));
            if (v.is_d && v.we) chk("mem_wdata", 64'(mem_wdata), 64'(v.wdata));
            if (v.drop && issue_n == 1) begin i_req = 1'b0; d_req = 1'b0; end
            if (issue_n == v.wt + 1) begin
               mem_ack   = 1'b1;
               mem_rdata = v.we ? 32'h5555_AAAA : v.rdata;
            end
         end
         if (i_ready || d_ready) begin
            g = sb.pop_front();
            chk("ready_port", 64'({i_ready, d_ready}), 64'({!g.is_d, g.is_d}));
            chk("latency", 64'(cyc), 64'(g.lat));
            chk("issue_cycles", 64'(issue_n), 64'(v.wt + 1));
            chk("rdata", 64'(g.is_d ? d_rdata : i_rdata), 64'(g.rdata));
            i_req = 1'b0; d_req = 1'b0;
            mem_ack   = v.stray;
            mem_rdata = 32'hBAD0_BAD0;
            done = 1;
         end
         step();
         cyc++;
      end
      if (!done) begin
         chk("ready_timeout", 64'(cyc), 64'(e.lat));
         void'(sb.pop_front());
      end
      mem_ack = 1'b0;
      chk("post_ready", 64'({i_ready, d_ready, mem_req}), 64'(0));
      chk("post_rdata", 64'({i_rdata, d_rdata}), 64'({exp_i, exp_d}));
   endtask

   // Auto-acking memory; compares the order of ready pulses against port_q.
   task automatic run_stream();
      int  cyc;
      logic p;
      cyc = 0;
      while (port_q.size() != 0 && cyc < 200) begin
         step();
         cyc++;
         mem_ack   = mem_req;
         mem_rdata = 32'h0000_1000 + 32'(cyc);
         if (i_ready || d_ready) begin
            p = port_q.pop_front();
            chk("grant_order", 64'({i_ready, d_ready}), 64'({!p, p}));
         end
      end
      mem_ack = 1'b0;
      if (port_q.size() != 0) begin
         chk("stream_timeout", 64'(port_q.size()), 64'(0));
         port_q.delete();
      end
   endtask

   initial begin
      vecs[0] = '{1'b0, 1'b0, 32'h0000_0040, 32'h0, 32'h2402_0005, 0, 1'b0, 1'b0};
      vecs[1] = '{1'b1, 1'b1, 32'h1000_0004, 32'hDEAD_BEEF, 32'h0, 3, 1'b0, 1'b0};
      vecs[2] = '{1'b1, 1'b0, 32'h1000_0004, 32'h0, 32'hDEAD_BEEF, 1, 1'b0, 1'b1};
      vecs[3] = '{1'b0, 1'b0, 32'h0000_0044, 32'h0, 32'h8C43_0000, 2, 1'b1, 1'b0};
      vecs[4] = '{1'b1, 1'b0, 32'h0000_0020, 32'h0, 32'h1234_5678, 0, 1'b1, 1'b1};
      vecs[5] = '{1'b1, 1'b1, 32'h0000_0024, 32'hCAFE_F00D, 32'h0, 0, 1'b0, 1'b0};

      rst = 1'b1; i_req = 0; d_req = 0; d_we = 0; mem_ack = 0;
      i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
      repeat (3) step();
      chk("reset_ctrl", 64'({mem_req, mem_we, i_ready, d_ready}), 64'(0));
      chk("reset_mem", 64'({mem_addr, mem_wdata}), 64'(0));
      chk("reset_rdata", 64'({i_rdata, d_rdata}), 64'(0));
      rst = 1'b0;
      step();

      for (int k = 0; k < 6; k++) begin
         do_access(vecs[k]);
         step();
      end

      // Ack pulsed in IDLE must do nothing.
      mem_ack = 1'b1; mem_rdata = 32'hFFFF_0000;
      step();
      mem_ack = 1'b0;
      step();
      chk("idle_ack_ctrl", 64'({mem_req, i_ready, d_ready}), 64'(0));
      chk("idle_ack_rdata", 64'({i_rdata, d_rdata}), 64'({exp_i, exp_d}));

      // D-only loads, then fetch joins while D keeps requesting.
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
      repeat (3) port_q.push_back(1'b1);
      run_stream();
      i_req = 1'b1; i_addr = 32'h200;
      repeat (4) port_q.push_back(1'b1);
      port_q.push_back(1'b0);
      run_stream();

      // Both held: D,D,D,D,I twice.
      for (int r = 0; r < 2; r++) begin
         repeat (4) port_q.push_back(1'b1);
         port_q.push_back(1'b0);
      end
      run_stream();
      i_req = 1'b0; d_req = 1'b0;
      step(); step();
      chk("stream_idle", 64'({mem_req, i_ready, d_ready}), 64'(0));

      // Reset during ISSUE with a coincident ack.
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h30;
      step();
      chk("issue_before_rst", 64'(mem_req), 64'(1));
      rst = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
      step();
      rst = 1'b0; mem_ack = 1'b0; d_req = 1'b0;
      chk("rst_ctrl", 64'({mem_req, mem_we, i_ready, d_ready}), 64'(0));
      chk("rst_rdata", 64'({i_rdata, d_rdata}), 64'(0));
      chk("rst_addr", 64'(mem_addr), 64'(0));
      for (int k = 0; k < 3; k++) begin
         step();
         chk("rst_quiet", 64'({mem_req, i_ready, d_ready}), 64'(0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-ported unified memory between the fetch stage (I port) and the memory stage (D port) of the 5-stage MIPS pipeline.
- Sequences each access with a req/ack handshake to the memory and returns a one-cycle ready pulse to the winning requester. The pipeline holds its stall while ready is low.
- Data accesses have priority. A starvation counter guarantees that fetch gets serviced.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- STARVE_MAX, 4, maximum consecutive D grants while i_req is pending; range 1..15.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- i_req  in  1  fetch request; held high until i_ready.
- i_addr  in  ADDR_W  fetch address; stable while i_req is high.
- i_rdata  out  DATA_W  fetch data; registered, valid when i_ready is high, held until the next I read.
- i_ready  out  1  one-cycle completion pulse for an I access.
- d_req  in  1  data request; held high until d_ready.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_rdata  out  DATA_W  load data; registered, valid when d_ready is high, held until the next D load.
- d_ready  out  1  one-cycle completion pulse for a D access.
- mem_req  out  1  memory request, held until mem_ack.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address (registered).
- mem_wdata  out  DATA_W  memory write data (registered).
- mem_rdata  in  DATA_W  memory read data, valid in the mem_ack cycle.
- mem_ack  in  1  memory completion, 1 cycle; may arrive in the same cycle mem_req rises.

Behaviour:
- Reset: state=IDLE, owner=I, starve_cnt=0. mem_req, mem_we, i_ready and d_ready are 0. mem_addr, mem_wdata, i_rdata and d_rdata are 0.
- FSM states are IDLE, ISSUE and RESP.
- IDLE: requests are sampled.
  - If d_req=1 and (i_req=0 or starve_cnt<STARVE_MAX): grant D.
  - Else if i_req=1: grant I.
  - On a grant: latch addr/we/wdata from the winner into the mem_* registers, record owner, go to ISSUE.
  - With no request, stay in IDLE.
- ISSUE: mem_req=1 and mem_we=owner_we (always 0 for I). mem_* outputs stay stable.
  - On mem_ack=1: capture mem_rdata into the owner's rdata register, but only for reads (D stores leave d_rdata unchanged). Go to RESP.
  - With no ack, stay in ISSUE indefinitely; there is no timeout.
- RESP: owner's ready=1 for exactly one cycle, mem_req=0, then go to IDLE. Requests are ignored in RESP.
- Requesters deassert req at the edge on which they sample ready=1. A req still high in the following IDLE cycle is treated as a new access.
- Latency: a request seen in IDLE at cycle 0 with ack in the first ISSUE cycle gives ready in cycle 2. Each additional ack wait cycle adds 1. Back-to-back accesses to one port take 3 cycles minimum.
- Starvation counter:
  - On a D grant while i_req=1: starve_cnt += 1, saturating at STARVE_MAX.
  - On any I grant: starve_cnt=0.
  - On a D grant with i_req=0: starve_cnt=0.
- Simultaneous i_req and d_req in IDLE: D wins unless starve_cnt==STARVE_MAX.
- Requester drops req during ISSUE (illegal but tolerated): the access still completes and ready still pulses.
- rst asserted mid-access: immediate return to reset values on the next edge. mem_req drops, and the in-flight ack (if any) is ignored.
- mem_ack while not in ISSUE: ignored.
- Outputs i_ready, d_ready and mem_req are decoded from registered state only; there is no combinational path from any input.

Decomposition:
- Shared package mips_pkg: state enum constants (ARB_IDLE=2'd0, ARB_ISSUE=2'd1, ARB_RESP=2'd2) and owner encoding (OWN_I=1'b0, OWN_D=1'b1).
- One sub-module is natural: arb_starve_cnt, the saturating counter with its grant/clear logic, width $clog2(STARVE_MAX+1).
- The FSM and datapath registers stay in mem_arbiter.

Test Plan:
- I-only read: i_req=1, i_addr=0x0000_0040, memory acks in the first ISSUE cycle with 0x2402_0005 -> mem_req high 1 cycle, mem_addr=0x40, mem_we=0; i_ready in cycle 2 with i_rdata=0x2402_0005; d_ready stays 0.
- D store with 3 wait cycles: d_req=1, d_we=1, d_addr=0x1000_0004, d_wdata=0xDEAD_BEEF; ack arrives on the 4th ISSUE cycle -> mem_we=1 and mem_wdata=0xDEAD_BEEF stable for all 4 cycles; d_ready pulses once, in cycle 5; d_rdata unchanged (0).
- Simultaneous requests, STARVE_MAX=4: i_req and d_req both held continuously, requesters re-request immediately -> grant order D,D,D,D,I,D,D,D,D,I; starve_cnt reaches 4 before each I grant.
- D priority without contention: i_req=0 with repeated d_req loads -> every grant goes to D and starve_cnt stays 0; raising i_req later gives its first grant after 4 further D grants if d_req stays high.
- Reset mid-access: rst=1 during ISSUE, then mem_ack=1 arrives in the same cycle -> next cycle state=IDLE, mem_req=0, no ready pulse, rdata registers=0.
- Ack outside ISSUE: mem_ack=1 pulsed in IDLE and RESP -> no state change, no rdata capture, no extra ready pulse.
